diff_job_sequencer: RTL
=======================

# diff_job_sequencer

Upstream/downstream companion to the `differentiator` block that converts whole jobs into its operand-load protocol. It accepts one job (x, dx, u, a) through a valid/ready handshake and loads the four operands serially over `s1..s4`/`in`. It then pulses `ready`, waits for the differentiator's `valid`, captures the 16-bit result, and presents it on a valid/ready result port, with a watchdog timeout.

## Interface
- `TIMEOUT_CYCLES`, default 1023: maximum cycles in WAIT before the job is aborted with an error.
- `OPW`, default 4: operand width; must match the differentiator's `in`.
- `RESW`, default 16: result width; must match the differentiator's `out`.

- `clk`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately.
- `job_valid`  in  1  a job is offered.
- `job_ready`  out  1  the sequencer accepts a job this cycle.
- `job_x`, `job_dx`, `job_u`, `job_a`  in  OPW each  job operands.
- `d_s1`, `d_s2`, `d_s3`, `d_s4`  out  1 each  operand selects to the differentiator; at most one is high.
- `d_in`  out  OPW  operand value driven to the differentiator.
- `d_ready`  out  1  one-cycle start pulse to the differentiator.
- `d_valid`  in  1  differentiator result valid.
- `d_out`  in  RESW  differentiator result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  RESW  captured result; 0 on timeout.
- `res_err`  out  1  set when the job timed out; qualified by `res_valid`.
- `busy`  out  1  high in every state except IDLE.
- `job_count`  out  8  number of completed jobs (result handshakes); wraps from 255 to 0.

## Operation
- **FSM states:** IDLE, LD_X, LD_DX, LD_U, LD_A, START, WAIT, DONE.
- **IDLE**
  - `job_ready`=1.
  - On `job_valid && job_ready`, register all four operands and go to LD_X.
- **LD_X / LD_DX / LD_U / LD_A**
  - One cycle each, in that order.
  - Drive `d_s1` / `d_s2` / `d_s3` / `d_s4` respectively, with `d_in` = the matching registered operand.
  - All other selects are 0.
- **START**
  - `d_ready`=1 for exactly one cycle; selects are all 0.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - If `d_valid`=1: capture `d_out` into `res_data`, `res_err`=0, go to DONE.
  - Else, if counter == TIMEOUT_CYCLES−1: `res_data`=0, `res_err`=1, go to DONE.
  - If `d_valid` arrives in the same cycle as the timeout, the result wins.
- **DONE**
  - `res_valid`=1; `res_data` and `res_err` are held stable.
  - On `res_ready`, increment `job_count` and return to IDLE.
- **Ignored inputs:**
  - `d_valid` outside WAIT.
  - `job_valid` outside IDLE (`job_ready`=0 there).
- **Outputs when not being driven:** in every state other than the LD_* states, `d_in`=0 and all selects are 0.

## Timing
- **Reset values:**
  - `job_ready`=1 (IDLE).
  - All `d_s*`=0, `d_in`=0, `d_ready`=0.
  - `res_valid`=0, `res_data`=0, `res_err`=0.
  - `busy`=0, `job_count`=0.
- **Job acceptance to load:** the job is accepted at edge N; `d_s1` is high in cycle N+1; `d_s4` is high in N+4; `d_ready` is high in N+5; WAIT begins at N+6.
- **Result path:** if `d_valid` is first seen in cycle W, `res_valid` rises in W+1.
- **Timeout:** with no `d_valid`, `res_valid` rises exactly TIMEOUT_CYCLES cycles after WAIT is entered.
- **Return to IDLE:** a `res_ready` handshake at edge R returns the FSM to IDLE, so `job_ready`=1 in R+1.
- **Throughput:** minimum job period is 8 cycles (accept, 4 loads, start, ≥1 wait, done).
- **Reset mid-job:** returns to IDLE at once, with all outputs at their reset values; the in-flight job is dropped and not counted.
- **Output registering:** all outputs are registered except `job_ready`, `busy` and `res_valid`, which decode directly from the state register.

## Structure
- **Shared package `diff_pkg`:**
  - State enum `seq_state_t`.
  - Widths OPW=4 and RESW=16.
  - Default TIMEOUT_CYCLES.
- **Sub-module:** one, `diff_watchdog`: a loadable down-counter with clear/enable and a `expired` output.
- **Sizing:** timeout counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- **Basic job:** job x=2, dx=1, u=3, a=5, with a differentiator model returning 0x1234 three cycles after `d_ready`. Expect:
  - `d_s1`..`d_s4` fire in order with `d_in` = 2, 1, 3, 5.
  - `res_data`=0x1234, `res_err`=0.
  - `job_count`=1.
- **Timeout:** TIMEOUT_CYCLES=8 and `d_valid` never asserted. Expect:
  - `res_valid` rises 8 cycles after WAIT entry.
  - `res_err`=1, `res_data`=0.
- **Backpressure:** hold `res_ready`=0 for 10 cycles while a second job is offered. Expect:
  - `res_data` stays stable throughout.
  - `job_ready`=0 until the result handshake completes.
  - The second job loads afterwards.
- **Spurious valid:** pulse `d_valid` during LD_U. Expect it to be ignored: no capture, and the sequence continues normally.
- **Reset mid-job:** assert `reset`=0 during WAIT. Expect:
  - All outputs take their reset values asynchronously.
  - `job_count` unchanged at 0.
- **Counter wrap:** run 256 back-to-back jobs. Expect `job_count` to wrap to 0, with every result matching the model.

Source files
------------

// File: rtl/diff_pkg.sv
// Shared types and defaults for the differentiator job sequencer.
// Operand/result widths must match the differentiator they drive.
package diff_pkg;

  localparam int DIFF_OPW     = 4;
  localparam int DIFF_RESW    = 16;
  localparam int DIFF_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_X,
    S_LD_DX,
    S_LD_U,
    S_LD_A,
    S_START,
    S_WAIT,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/diff_watchdog.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Loading N-1 makes expired rise on the N-th enabled cycle.
module diff_watchdog #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/diff_job_sequencer.sv
// Feeds one job at a time into the differentiator operand-load
// protocol and returns its result over a valid/ready port.
module diff_job_sequencer
  import diff_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DIFF_TIMEOUT,
  parameter int OPW            = DIFF_OPW,
  parameter int RESW           = DIFF_RESW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            job_valid,
  output logic            job_ready,
  input  logic [OPW-1:0]  job_x,
  input  logic [OPW-1:0]  job_dx,
  input  logic [OPW-1:0]  job_u,
  input  logic [OPW-1:0]  job_a,
  output logic            d_s1,
  output logic            d_s2,
  output logic            d_s3,
  output logic            d_s4,
  output logic [OPW-1:0]  d_in,
  output logic            d_ready,
  input  logic            d_valid,
  input  logic [RESW-1:0] d_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RESW-1:0] res_data,
  output logic            res_err,
  output logic            busy,
  output logic [7:0]      job_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WD_LOAD = CW'(TIMEOUT_CYCLES - 1);

  seq_state_t state;
  logic [2:0][OPW-1:0] pend;
  logic wd_expired;

  assign job_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_DONE);

  diff_watchdog #(.CW(CW)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .clr      (state == S_IDLE),
    .load     (state == S_START),
    .en       (state == S_WAIT),
    .load_val (WD_LOAD),
    .expired  (wd_expired)
  );

  // Select/operand outputs are registered, so each is set on the
  // edge that enters the state where it must be visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pend      <= '0;
      d_s1      <= 1'b0;
      d_s2      <= 1'b0;
      d_s3      <= 1'b0;
      d_s4      <= 1'b0;
      d_in      <= '0;
      d_ready   <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      job_count <= '0;
    end else begin
      d_s1    <= 1'b0;
      d_s2    <= 1'b0;
      d_s3    <= 1'b0;
      d_s4    <= 1'b0;
      d_in    <= '0;
      d_ready <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (job_valid) begin
            pend  <= {job_a, job_u, job_dx};
            d_s1  <= 1'b1;
            d_in  <= job_x;
            state <= S_LD_X;
          end
        end
        S_LD_X: begin
          d_s2  <= 1'b1;
          d_in  <= pend[0];
          state <= S_LD_DX;
        end
        S_LD_DX: begin
          d_s3  <= 1'b1;
          d_in  <= pend[1];
          state <= S_LD_U;
        end
        S_LD_U: begin
          d_s4  <= 1'b1;
          d_in  <= pend[2];
          state <= S_LD_A;
        end
        S_LD_A: begin
          d_ready <= 1'b1;
          state   <= S_START;
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (d_valid) begin
            res_data <= d_out;
            res_err  <= 1'b0;
            state    <= S_DONE;
          end else if (wd_expired) begin
            res_data <= '0;
            res_err  <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            job_count <= job_count + 8'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
